// File: rtl/bt_tx_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bt_tx_scheduler: arbitrates ack/move frame requests and serialises a     |
// | 5-byte frame to the UART transmitter with a per-byte timeout. Rev 1.0    |
// +--------------------------------------------------------------------------+
module bt_tx_scheduler #(
  parameter int unsigned TIMEOUT = 8192,
  parameter logic [7:0]  HEADER  = 8'hAA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ack_req,
  input  logic [7:0] ack_x,
  input  logic [7:0] ack_y,
  input  logic       mv_req,
  input  logic [7:0] mv_x,
  input  logic [7:0] mv_y,
  output logic       ack_gnt,
  output logic       mv_gnt,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done_tick,
  output logic       busy,
  output logic       frame_done,
  output logic       err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [7:0]  C_TYPE_ACK = 8'h01;
  localparam logic [7:0]  C_TYPE_MV  = 8'h02;
  // Counter value from which one more idle cycle means expiry.
  localparam logic [15:0] C_CNT_LAST = 16'(TIMEOUT - 2);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_idx, w_idx_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_last_mv, w_last_mv_nxt;
  logic [7:0]  r_type, w_type_nxt;
  logic [7:0]  r_x, w_x_nxt;
  logic [7:0]  r_y, w_y_nxt;
  logic [7:0]  r_chk, w_chk_nxt;
  logic [7:0]  w_tx_data_nxt;
  logic [7:0]  w_byte_next;
  logic        w_ack_gnt_nxt, w_mv_gnt_nxt, w_tx_start_nxt;
  logic        w_busy_nxt, w_frame_done_nxt, w_err_nxt;
  logic        w_pick_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= 3'd0;
      r_cnt      <= 16'd0;
      r_last_mv  <= 1'b1;
      r_type     <= 8'h00;
      r_x        <= 8'h00;
      r_y        <= 8'h00;
      r_chk      <= 8'h00;
      ack_gnt    <= 1'b0;
      mv_gnt     <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_last_mv  <= w_last_mv_nxt;
      r_type     <= w_type_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_chk      <= w_chk_nxt;
      ack_gnt    <= w_ack_gnt_nxt;
      mv_gnt     <= w_mv_gnt_nxt;
      tx_start   <= w_tx_start_nxt;
      tx_data    <= w_tx_data_nxt;
      busy       <= w_busy_nxt;
      frame_done <= w_frame_done_nxt;
      err        <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_cnt_nxt        = r_cnt;
    w_last_mv_nxt    = r_last_mv;
    w_type_nxt       = r_type;
    w_x_nxt          = r_x;
    w_y_nxt          = r_y;
    w_chk_nxt        = r_chk;
    w_tx_data_nxt    = tx_data;
    w_ack_gnt_nxt    = 1'b0;
    w_mv_gnt_nxt     = 1'b0;
    w_tx_start_nxt   = 1'b0;
    w_frame_done_nxt = 1'b0;
    w_err_nxt        = 1'b0;
    // On a tie the requester not served last wins.
    w_pick_ack       = ack_req && (!mv_req || r_last_mv);

    case (r_idx)
      3'd0:    w_byte_next = r_type;
      3'd1:    w_byte_next = r_x;
      3'd2:    w_byte_next = r_y;
      default: w_byte_next = r_chk;
    endcase

    case (r_state)
      IDLE: begin
        if (ack_req || mv_req) begin
          w_state_nxt    = WAIT;
          w_idx_nxt      = 3'd0;
          w_cnt_nxt      = 16'd0;
          w_tx_start_nxt = 1'b1;
          w_tx_data_nxt  = HEADER;
          if (w_pick_ack) begin
            w_type_nxt    = C_TYPE_ACK;
            w_x_nxt       = ack_x;
            w_y_nxt       = ack_y;
            w_chk_nxt     = C_TYPE_ACK ^ ack_x ^ ack_y;
            w_ack_gnt_nxt = 1'b1;
            w_last_mv_nxt = 1'b0;
          end else begin
            w_type_nxt    = C_TYPE_MV;
            w_x_nxt       = mv_x;
            w_y_nxt       = mv_y;
            w_chk_nxt     = C_TYPE_MV ^ mv_x ^ mv_y;
            w_mv_gnt_nxt  = 1'b1;
            w_last_mv_nxt = 1'b1;
          end
        end
      end
      WAIT: begin
        if (tx_done_tick) begin
          if (r_idx == 3'd4) begin
            w_state_nxt      = IDLE;
            w_frame_done_nxt = 1'b1;
          end else begin
            w_idx_nxt      = r_idx + 3'd1;
            w_cnt_nxt      = 16'd0;
            w_tx_start_nxt = 1'b1;
            w_tx_data_nxt  = w_byte_next;
          end
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_bt_tx_scheduler.sv
`default_nettype none
// Bench for bt_tx_scheduler: frame table, round-robin, timeout, reset and random
// frames checked against a frame-level model.
module tb_bt_tx_scheduler;

  localparam int         TO  = 16;
  localparam logic [7:0] HDR = 8'hAA;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ack_req = 1'b0, mv_req = 1'b0, tx_done_tick = 1'b0;
  logic [7:0] ack_x = 8'h00, ack_y = 8'h00, mv_x = 8'h00, mv_y = 8'h00;
  logic       ack_gnt, mv_gnt, tx_start, busy, frame_done, err;
  logic [7:0] tx_data;

  always #5 clk = ~clk;

  bt_tx_scheduler #(.TIMEOUT(TO), .HEADER(HDR)) dut (
    .clk(clk), .rst(rst),
    .ack_req(ack_req), .ack_x(ack_x), .ack_y(ack_y),
    .mv_req(mv_req), .mv_x(mv_x), .mv_y(mv_y),
    .ack_gnt(ack_gnt), .mv_gnt(mv_gnt),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done_tick(tx_done_tick),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  int n_cmp = 0, n_fail = 0, cyc = 0;
  bit model_last_mv = 1'b1;

  // Observations from the last run_frame call.
  int         g_ack, g_mv, g_gcyc, g_gbusy, g_nstart, g_last_done;
  int         g_fd_cyc, g_fd_busy, g_err_cyc, g_err_busy, g_nfd, g_nerr;
  bit         g_ended;
  logic [7:0] g_b[5];
  int         g_st[5];

  typedef struct packed {
    logic        a;
    logic        m;
    logic [7:0]  ax, ay, mx, my;
    int          lat;
    logic        exp_ack;
    logic [39:0] exp_bytes;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [39:0] model_frame(input bit is_ack, input logic [7:0] x,
                                              input logic [7:0] y);
    logic [7:0] t;
    t = is_ack ? 8'h01 : 8'h02;
    return {HDR, t, x, y, t ^ x ^ y};
  endfunction

  function automatic bit model_pick_ack(input bit a, input bit m);
    if (a && m) return model_last_mv;
    return a;
  endfunction

  // Runs one frame as the transmitter: tx_done lat cycles after each tx_start,
  // except byte index hang which never completes.
  task automatic run_frame(input int lat, input int hang, input bit drop);
    int done_at;
    done_at = -1;
    g_ack = 0; g_mv = 0; g_gcyc = -1; g_gbusy = 0; g_nstart = 0; g_last_done = -1;
    g_fd_cyc = -1; g_fd_busy = 1; g_err_cyc = -1; g_err_busy = 1; g_nfd = 0; g_nerr = 0;
    g_ended = 1'b0;
    for (int i = 0; i < 5; i++) begin g_b[i] = 8'h00; g_st[i] = -1; end
    for (int k = 0; k < 400; k++) begin
      tick();
      tx_done_tick = 1'b0;
      if (ack_gnt) begin g_ack++; g_gcyc = cyc; g_gbusy = busy; end
      if (mv_gnt)  begin g_mv++;  g_gcyc = cyc; g_gbusy = busy; end
      if ((ack_gnt || mv_gnt) && drop) begin
        ack_req = 1'b0; mv_req = 1'b0;
        ack_x = 8'($urandom); ack_y = 8'($urandom);
        mv_x  = 8'($urandom); mv_y  = 8'($urandom);
      end
      if (tx_start) begin
        if (g_nstart < 5) begin g_b[g_nstart] = tx_data; g_st[g_nstart] = cyc; end
        if (g_nstart != hang) done_at = cyc + lat;
        g_nstart++;
      end
      if (cyc == done_at) begin tx_done_tick = 1'b1; g_last_done = cyc; done_at = -1; end
      if (frame_done) begin g_nfd++; g_fd_cyc = cyc; g_fd_busy = busy; end
      if (err) begin g_nerr++; g_err_cyc = cyc; g_err_busy = busy; end
      if (frame_done || err) begin g_ended = 1'b1; tx_done_tick = 1'b0; break; end
    end
  endtask

  task automatic check_frame(input string tag, input bit exp_ack, input logic [39:0] exp_b);
    chk({tag, "_ended"}, g_ended, 1);
    chk({tag, "_ack_gnt"}, g_ack, exp_ack ? 1 : 0);
    chk({tag, "_mv_gnt"}, g_mv, exp_ack ? 0 : 1);
    chk({tag, "_busy_at_gnt"}, g_gbusy, 1);
    chk({tag, "_nstart"}, g_nstart, 5);
    chk({tag, "_bytes"}, {g_b[0], g_b[1], g_b[2], g_b[3], g_b[4]}, exp_b);
    chk({tag, "_hdr_same_cycle_as_gnt"}, g_st[0], g_gcyc);
    chk({tag, "_fd_latency"}, g_fd_cyc, g_last_done + 1);
    chk({tag, "_fd_busy"}, g_fd_busy, 0);
    chk({tag, "_err"}, g_nerr, 0);
  endtask

  initial begin
    logic [39:0] eb;
    bit          pa;
    int          seen, dn, bad, prev_done;
    logic [7:0]  tx, ty;

    tbl[0] = '{1'b1, 1'b0, 8'h03, 8'h07, 8'h00, 8'h00, 5,  1'b1, 40'hAA01030705};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h0A, 8'h0E, 3,  1'b0, 40'hAA020A0E06};
    tbl[2] = '{1'b1, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 14, 1'b1, 40'hAA01112232};
    tbl[3] = '{1'b1, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 1,  1'b0, 40'hAA02334475};

    // Reset state
    tick(); tick();
    chk("reset_outputs", {ack_gnt, mv_gnt, tx_start, busy, frame_done, err, tx_data}, 0);
    rst = 1'b0;
    tick();
    chk("post_reset_outputs", {ack_gnt, mv_gnt, tx_start, busy, frame_done, err, tx_data}, 0);

    // Stray tx_done in IDLE is ignored
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    tick();
    chk("idle_done_ignored", {tx_start, busy, frame_done, err}, 0);

    // Table-driven frames (row 2 completes a byte exactly on the expiry cycle)
    for (int r = 0; r < 4; r++) begin
      ack_req = tbl[r].a; mv_req = tbl[r].m;
      ack_x = tbl[r].ax; ack_y = tbl[r].ay; mv_x = tbl[r].mx; mv_y = tbl[r].my;
      run_frame(tbl[r].lat, -1, 1'b1);
      check_frame($sformatf("tbl%0d", r), tbl[r].exp_ack, tbl[r].exp_bytes);
      model_last_mv = !tbl[r].exp_ack;
      ack_req = 1'b0; mv_req = 1'b0;
      tick();
    end

    // Timeout on byte index 1, then a normal frame
    ack_req = 1'b1; ack_x = 8'h5C; ack_y = 8'h3E;
    run_frame(3, 1, 1'b1);
    model_last_mv = 1'b0;
    chk("to_ended", g_ended, 1);
    chk("to_err", g_nerr, 1);
    chk("to_no_fd", g_nfd, 0);
    chk("to_nstart", g_nstart, 2);
    chk("to_err_latency", g_err_cyc, g_st[1] + TO - 1);
    chk("to_busy_low", g_err_busy, 0);
    chk("to_bytes", {g_b[0], g_b[1]}, {HDR, 8'h01});
    ack_req = 1'b0;
    tick();
    mv_req = 1'b1; mv_x = 8'h21; mv_y = 8'h42;
    run_frame(2, -1, 1'b1);
    check_frame("after_to", 1'b0, model_frame(1'b0, 8'h21, 8'h42));
    model_last_mv = 1'b1;
    tick();

    // Round-robin with both requests held across frames
    ack_req = 1'b1; mv_req = 1'b1;
    ack_x = 8'h01; ack_y = 8'h02; mv_x = 8'h03; mv_y = 8'h04;
    prev_done = -1;
    for (int f = 0; f < 4; f++) begin
      pa = model_pick_ack(1'b1, 1'b1);
      chk($sformatf("rr%0d_expect_order", f), pa, (f % 2 == 0) ? 1 : 0);
      eb = pa ? model_frame(1'b1, ack_x, ack_y) : model_frame(1'b0, mv_x, mv_y);
      run_frame(4, -1, 1'b0);
      check_frame($sformatf("rr%0d", f), pa, eb);
      if (f > 0) chk($sformatf("rr%0d_gap", f), g_gcyc, prev_done + 2);
      prev_done = g_last_done;
      model_last_mv = !pa;
    end
    ack_req = 1'b0; mv_req = 1'b0;
    tick();

    // Reset during byte 3
    mv_req = 1'b1; mv_x = 8'h66; mv_y = 8'h77;
    seen = 0; dn = -1;
    for (int k = 0; k < 200 && seen < 3; k++) begin
      tick();
      tx_done_tick = 1'b0;
      if (mv_gnt) mv_req = 1'b0;
      if (tx_start) begin seen++; if (seen < 3) dn = cyc + 2; end
      if (cyc == dn) tx_done_tick = 1'b1;
    end
    tx_done_tick = 1'b0;
    chk("rst_pre_bytes", seen, 3);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_async_outputs", {ack_gnt, mv_gnt, tx_start, busy, frame_done, err, tx_data}, 0);
    ack_req = 1'b1; mv_req = 1'b1;
    ack_x = 8'h10; ack_y = 8'h20; mv_x = 8'h30; mv_y = 8'h40;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (tx_start || busy || ack_gnt || mv_gnt || frame_done || err) bad++;
    end
    chk("rst_held_quiet", bad, 0);
    rst = 1'b0;
    model_last_mv = 1'b1;
    for (int f = 0; f < 2; f++) begin
      pa = model_pick_ack(1'b1, 1'b1);
      eb = pa ? model_frame(1'b1, ack_x, ack_y) : model_frame(1'b0, mv_x, mv_y);
      run_frame(2, -1, 1'b0);
      check_frame($sformatf("post_rst%0d", f), pa, eb);
      model_last_mv = !pa;
    end
    chk("post_rst_first_is_ack", g_mv, 1);
    ack_req = 1'b0; mv_req = 1'b0;
    tick();

    // Random frames against the model
    for (int it = 0; it < 30; it++) begin
      int sel;
      sel = $urandom_range(1, 3);
      ack_req = sel[0]; mv_req = sel[1];
      ack_x = 8'($urandom); ack_y = 8'($urandom);
      mv_x  = 8'($urandom); mv_y  = 8'($urandom);
      pa = model_pick_ack(ack_req, mv_req);
      tx = pa ? ack_x : mv_x;
      ty = pa ? ack_y : mv_y;
      run_frame($urandom_range(1, TO - 2), -1, 1'b1);
      check_frame($sformatf("rnd%0d", it), pa, model_frame(pa, tx, ty));
      model_last_mv = !pa;
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
